// File: rtl/wb_timer_irq.sv
// Wishbone classic timer: one prescaled free-running counter shared by NUM_CH
// compare channels (one-shot or periodic), each with a sticky, maskable interrupt.
module wb_timer_irq #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [7:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic              irq_any_o
);

  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_CH-1:0]  pending_q, pending_d;
  logic [NUM_CH-1:0]  irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]  ch_en_q, ch_en_d;
  logic [NUM_CH-1:0]  periodic_q, periodic_d;
  logic [CNT_W-1:0]   cmp_q [NUM_CH];
  logic [CNT_W-1:0]   cmp_d [NUM_CH];
  logic [CNT_W-1:0]   reload_q [NUM_CH];
  logic [CNT_W-1:0]   reload_d [NUM_CH];
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        dat_q, dat_d;
  logic [NUM_CH-1:0]  irq_q, irq_d;

  logic              req, wr, mapped;
  logic              hit_ctrl, hit_presc, hit_count, hit_status, hit_irqen;
  logic [NUM_CH-1:0] hit_cmp, hit_reload, hit_chctrl;
  logic [31:0]       rdata, lane_mask, wval;
  logic              tick, clr, count_wr;
  logic [CNT_W-1:0]  count_inc;
  logic [NUM_CH-1:0] match;
  logic              unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  // Address decode, read mux and byte-lane merge of write data over the current value.
  // NOTE: every signal gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    req        = wb_cyc_i & wb_stb_i & ~(ack_q | err_q);
    wr         = req & wb_we_i;
    hit_ctrl   = (wb_adr_i[7:2] == 6'h00);
    hit_presc  = (wb_adr_i[7:2] == 6'h01);
    hit_count  = (wb_adr_i[7:2] == 6'h02);
    hit_status = (wb_adr_i[7:2] == 6'h03);
    hit_irqen  = (wb_adr_i[7:2] == 6'h04);
    for (int c = 0; c < NUM_CH; c++) begin
      hit_cmp[c]    = (wb_adr_i[7:4] == 4'(c + 4)) && (wb_adr_i[3:2] == 2'd0);
      hit_reload[c] = (wb_adr_i[7:4] == 4'(c + 4)) && (wb_adr_i[3:2] == 2'd1);
      hit_chctrl[c] = (wb_adr_i[7:4] == 4'(c + 4)) && (wb_adr_i[3:2] == 2'd2);
    end
    mapped = hit_ctrl | hit_presc | hit_count | hit_status | hit_irqen |
             (|hit_cmp) | (|hit_reload) | (|hit_chctrl);

    rdata = '0;
    if (hit_ctrl)   rdata = {31'd0, en_q};
    if (hit_presc)  rdata = 32'(presc_q);
    if (hit_count)  rdata = 32'(count_q);
    if (hit_status) rdata = 32'(pending_q);
    if (hit_irqen)  rdata = 32'(irq_en_q);
    for (int c = 0; c < NUM_CH; c++) begin
      if (hit_cmp[c])    rdata = 32'(cmp_q[c]);
      if (hit_reload[c]) rdata = 32'(reload_q[c]);
      if (hit_chctrl[c]) rdata = {30'd0, periodic_q[c], ch_en_q[c]};
    end

    lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    wval      = (rdata & ~lane_mask) | (wb_dat_i & lane_mask);
  end

  // Timer datapath: hardware updates first, then software writes override them,
  // except pending where the hardware set is applied last so it beats a W1C.
  always_comb begin
    en_d       = en_q;
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
    count_d    = count_q;
    pending_d  = pending_q;
    irq_en_d   = irq_en_q;
    ch_en_d    = ch_en_q;
    periodic_d = periodic_q;
    cmp_d      = cmp_q;
    reload_d   = reload_q;

    tick      = en_q && (pcnt_q == presc_q);
    clr       = wr && hit_ctrl && wb_sel_i[0] && wb_dat_i[1];
    count_wr  = clr || (wr && hit_count);
    count_inc = count_q + CNT_W'(1);

    if (en_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
    if (tick) count_d = count_inc;

    for (int c = 0; c < NUM_CH; c++) begin
      match[c] = tick && !count_wr && ch_en_q[c] && (count_inc == cmp_q[c]);
      if (match[c]) begin
        if (periodic_q[c]) cmp_d[c] = cmp_q[c] + reload_q[c];
        else               ch_en_d[c] = 1'b0;
      end
    end

    if (wr) begin
      if (hit_ctrl) en_d = wval[0];
      if (clr) begin
        count_d = '0;
        pcnt_d  = '0;
      end
      if (hit_presc) begin
        presc_d = wval[PRESC_W-1:0];
        pcnt_d  = '0;
      end
      if (hit_count)  count_d   = wval[CNT_W-1:0];
      if (hit_status) pending_d = pending_q & ~(wb_dat_i[NUM_CH-1:0] & lane_mask[NUM_CH-1:0]);
      if (hit_irqen)  irq_en_d  = wval[NUM_CH-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (hit_cmp[c])    cmp_d[c]    = wval[CNT_W-1:0];
        if (hit_reload[c]) reload_d[c] = wval[CNT_W-1:0];
        if (hit_chctrl[c]) begin
          ch_en_d[c]    = wval[0];
          periodic_d[c] = wval[1];
        end
      end
    end

    pending_d = pending_d | match;

    ack_d = req & mapped;
    err_d = req & ~mapped;
    dat_d = (req && mapped && !wb_we_i) ? rdata : '0;
    irq_d = pending_q & irq_en_q;
  end

  // NOTE: state flops use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en_q       <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      irq_en_q   <= '0;
      ch_en_q    <= '0;
      periodic_q <= '0;
      // NOTE: the per-channel arrays are software-visible registers, so each element is reset, not left as RAM.
      for (int c = 0; c < NUM_CH; c++) begin
        cmp_q[c]    <= '0;
        reload_q[c] <= '0;
      end
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= '0;
    end else begin
      en_q       <= en_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      irq_en_q   <= irq_en_d;
      ch_en_q    <= ch_en_d;
      periodic_q <= periodic_d;
      cmp_q      <= cmp_d;
      reload_q   <= reload_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_dat_o  = dat_q;
  assign irq_o     = irq_q;
  assign irq_any_o = |irq_q;

endmodule
